// File: rtl/i2c_target_byte_if.sv
// Pin-side and register-side signals of the I2C target byte engine.
// The slave modport is the engine's view; master is the pad/register side.
interface i2c_target_byte_if;
    logic       i2c_sclk_i;
    logic       i2c_sda_i;
    logic       i2c_sda_o;
    logic       i2c_sda_e;
    logic [7:0] wr_data_out;
    logic       wr_data_out_en;
    logic       rd_data_req;
    logic [7:0] rd_data_in;
    logic       nack_det;
    logic       busy_flag;

    modport slave (
        input  i2c_sclk_i, i2c_sda_i, rd_data_in,
        output i2c_sda_o, i2c_sda_e, wr_data_out, wr_data_out_en,
               rd_data_req, nack_det, busy_flag
    );

    modport master (
        output i2c_sclk_i, i2c_sda_i, rd_data_in,
        input  i2c_sda_o, i2c_sda_e, wr_data_out, wr_data_out_en,
               rd_data_req, nack_det, busy_flag
    );
endinterface

// File: rtl/i2c_target_byte.sv
// I2C target byte engine: oversampled START/STOP detect, 7-bit address match, write/read byte transfer.
// Pin edge to strobe 3 clks, SDA enable 4 clks; no backpressure, rd_data_in must be ready by the next SCL fall.
module i2c_target_byte #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic              clk,
    input  logic              reset,
    i2c_target_byte_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
    } state_t;

    // Synchronizers reset to the idle-high bus level so no edge is seen on release.
    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= bus.i2c_sclk_i;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= bus.i2c_sda_i;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    logic scl_rise_d, scl_fall_d, start_d, stop_d;
    logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_q;

    assign scl_rise_d = scl_s2_q & ~scl_h_q;
    assign scl_fall_d = ~scl_s2_q & scl_h_q;
    assign start_d    = ~sda_s2_q & sda_h_q & scl_s2_q;
    assign stop_d     = sda_s2_q & ~sda_h_q & scl_s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_q      <= 1'b1;
        end else begin
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            sda_q      <= sda_s2_q;
        end
    end

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [7:0] sh_q;
    logic       rw_q;
    logic       ack_seen_q;
    logic       sda_e_q;
    logic       busy_q;
    logic       wr_en_q;
    logic [7:0] wr_dat_q;
    logic       req_q;
    logic       nack_q;
    logic [7:0] sh_in_d;

    assign sh_in_d = {sh_q[6:0], sda_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            sh_q       <= 8'h00;
            rw_q       <= 1'b0;
            ack_seen_q <= 1'b0;
            sda_e_q    <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_dat_q   <= 8'h00;
            req_q      <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            wr_en_q  <= 1'b0;
            wr_dat_q <= 8'h00;
            req_q    <= 1'b0;
            nack_q   <= 1'b0;
            if (start_q) begin
                state_q    <= ADDR;
                cnt_q      <= 4'd0;
                sda_e_q    <= 1'b0;
                ack_seen_q <= 1'b0;
            end else if (stop_q) begin
                state_q <= IDLE;
                cnt_q   <= 4'd0;
                sda_e_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: begin
                        if (scl_rise_q) begin
                            sh_q <= sh_in_d;
                            if (cnt_q == 4'd7) begin
                                cnt_q <= 4'd8;
                                if (sh_in_d[7:1] == DEV_ADDR) begin
                                    rw_q    <= sh_in_d[0];
                                    busy_q  <= 1'b1;
                                    state_q <= ADDR_ACK;
                                end else begin
                                    busy_q  <= 1'b0;
                                    state_q <= WAIT_STOP;
                                end
                            end else begin
                                cnt_q <= cnt_q + 4'd1;
                            end
                        end
                    end
                    // sda_e_q separates the fall that starts the ACK bit from the one that ends it.
                    ADDR_ACK: begin
                        if (scl_rise_q && sda_e_q) begin
                            req_q <= rw_q;
                        end else if (scl_fall_q) begin
                            if (!sda_e_q) begin
                                sda_e_q <= 1'b1;
                            end else if (rw_q) begin
                                sh_q    <= bus.rd_data_in;
                                sda_e_q <= ~bus.rd_data_in[7];
                                cnt_q   <= 4'd1;
                                state_q <= RD_BYTE;
                            end else begin
                                sda_e_q <= 1'b0;
                                cnt_q   <= 4'd0;
                                state_q <= WR_BYTE;
                            end
                        end
                    end
                    WR_BYTE: begin
                        if (scl_rise_q && (cnt_q != 4'd8)) begin
                            sh_q  <= sh_in_d;
                            cnt_q <= cnt_q + 4'd1;
                        end else if (scl_fall_q && (cnt_q == 4'd8)) begin
                            wr_dat_q <= sh_q;
                            wr_en_q  <= 1'b1;
                            sda_e_q  <= 1'b1;
                            cnt_q    <= 4'd0;
                            state_q  <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall_q) begin
                            sda_e_q <= 1'b0;
                            state_q <= WR_BYTE;
                        end
                    end
                    RD_BYTE: begin
                        if (scl_fall_q) begin
                            if (cnt_q == 4'd8) begin
                                sda_e_q    <= 1'b0;
                                cnt_q      <= 4'd0;
                                ack_seen_q <= 1'b0;
                                state_q    <= RD_ACK;
                            end else begin
                                sh_q    <= {sh_q[6:0], 1'b0};
                                sda_e_q <= ~sh_q[6];
                                cnt_q   <= cnt_q + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise_q && !ack_seen_q) begin
                            if (!sda_q) begin
                                req_q      <= 1'b1;
                                ack_seen_q <= 1'b1;
                            end else begin
                                nack_q  <= 1'b1;
                                state_q <= WAIT_STOP;
                            end
                        end else if (scl_fall_q && ack_seen_q) begin
                            sh_q       <= bus.rd_data_in;
                            sda_e_q    <= ~bus.rd_data_in[7];
                            cnt_q      <= 4'd1;
                            ack_seen_q <= 1'b0;
                            state_q    <= RD_BYTE;
                        end
                    end
                    default: begin
                        sda_e_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A START strobe releases SDA in the same clk rather than waiting for the state update.
    assign bus.i2c_sda_o      = 1'b0;
    assign bus.i2c_sda_e      = sda_e_q & ~start_q;
    assign bus.wr_data_out    = wr_dat_q;
    assign bus.wr_data_out_en = wr_en_q;
    assign bus.rd_data_req    = req_q;
    assign bus.nack_det       = nack_q;
    assign bus.busy_flag      = busy_q;

endmodule

// File: tb/tb_i2c_target_byte.sv
// Bench for i2c_target_byte: bit-banged I2C master, vector table, randomized transactions and corner sequences.
module tb_i2c_target_byte;

    localparam logic [6:0] DEV = 7'h50;
    localparam int Q = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    i2c_target_byte_if ifc();

    assign ifc.i2c_sclk_i = scl_m;
    assign ifc.i2c_sda_i  = sda_m & ~ifc.i2c_sda_e;

    i2c_target_byte #(.DEV_ADDR(DEV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    // Monitor-owned tallies; the main sequence only reads them.
    int viol = 0;
    int n_req = 0;
    int n_nack = 0;
    int n_drive = 0;
    logic [7:0] wr_q[$];

    initial begin
        logic prev_en, prev_req;
        prev_en  = 1'b0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.wr_data_out_en) wr_q.push_back(ifc.wr_data_out);
            else if (ifc.wr_data_out !== 8'h00) viol++;
            if (ifc.wr_data_out_en && prev_en) viol++;
            if (ifc.rd_data_req && prev_req) viol++;
            if (ifc.i2c_sda_o !== 1'b0) viol++;
            if (ifc.rd_data_req) n_req++;
            if (ifc.nack_det) n_nack++;
            if (ifc.i2c_sda_e) n_drive++;
            prev_en  = ifc.wr_data_out_en;
            prev_req = ifc.rd_data_req;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b1; wait_clks(2 * Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    wait_clks(Q);
        scl_m = 1'b1; wait_clks(2 * Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        b = ifc.i2c_sda_i;
        wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic put_byte(input logic [7:0] b, output logic ack_line);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(ack_line);
    endtask

    task automatic get_byte(output logic [7:0] b);
        logic x;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            get_bit(x);
            b = {b[6:0], x};
        end
    endtask

    // One complete transaction; the master stops right after an address NACK.
    task automatic do_txn(input logic [7:0] ab, input int n, input logic [23:0] d,
                          output logic addr_ack, output logic [2:0] dat_ack,
                          output logic [23:0] rd_b, output logic busy_mid);
        logic a;
        logic [7:0] rb;
        dat_ack = 3'b000;
        rd_b = 24'h0;
        if (ab[0]) ifc.rd_data_in = d[7:0];
        bus_start();
        put_byte(ab, a);
        addr_ack = ~a;
        if (addr_ack) begin
            for (int i = 0; i < n; i++) begin
                if (!ab[0]) begin
                    put_byte(d[8*i +: 8], a);
                    dat_ack[i] = ~a;
                end else begin
                    get_byte(rb);
                    rd_b[8*i +: 8] = rb;
                    if (i + 1 < n) ifc.rd_data_in = d[8*(i+1) +: 8];
                    put_bit(i == n - 1);
                end
            end
        end
        busy_mid = ifc.busy_flag;
        bus_stop();
    endtask

    task automatic run_and_check(input string tag, input logic [7:0] ab, input int n,
                                 input logic [23:0] d, input logic e_ack, input int e_wr,
                                 input logic [23:0] e_bytes, input int e_req,
                                 input int e_nack, input logic e_busy);
        int w0, r0, k0, v0;
        logic addr_ack, busy_mid;
        logic [2:0] dat_ack;
        logic [23:0] rd_b;
        w0 = wr_q.size(); r0 = n_req; k0 = n_nack; v0 = n_drive;
        do_txn(ab, n, d, addr_ack, dat_ack, rd_b, busy_mid);
        wait_clks(4);
        chk({tag, ".addr_ack"}, 32'(addr_ack), 32'(e_ack));
        if (e_ack && !ab[0])
            for (int i = 0; i < n; i++) chk($sformatf("%s.data_ack%0d", tag, i), 32'(dat_ack[i]), 32'd1);
        if (e_ack && ab[0])
            for (int i = 0; i < n; i++)
                chk($sformatf("%s.rd_byte%0d", tag, i), 32'(rd_b[8*i +: 8]), 32'(e_bytes[8*i +: 8]));
        chk({tag, ".wr_count"}, 32'(wr_q.size() - w0), 32'(e_wr));
        for (int i = 0; i < e_wr; i++)
            if (w0 + i < wr_q.size())
                chk($sformatf("%s.wr_byte%0d", tag, i), 32'(wr_q[w0 + i]), 32'(e_bytes[8*i +: 8]));
        chk({tag, ".rd_req"}, 32'(n_req - r0), 32'(e_req));
        chk({tag, ".nack_det"}, 32'(n_nack - k0), 32'(e_nack));
        chk({tag, ".busy_mid"}, 32'(busy_mid), 32'(e_busy));
        if (!e_ack) chk({tag, ".sda_quiet"}, 32'(n_drive - v0), 32'd0);
        chk({tag, ".busy_after"}, 32'(ifc.busy_flag), 32'd0);
        chk({tag, ".sda_e_after"}, 32'(ifc.i2c_sda_e), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".sda_e"},   32'(ifc.i2c_sda_e),      32'd0);
        chk({tag, ".sda_o"},   32'(ifc.i2c_sda_o),      32'd0);
        chk({tag, ".wr_data"}, 32'(ifc.wr_data_out),    32'd0);
        chk({tag, ".wr_en"},   32'(ifc.wr_data_out_en), 32'd0);
        chk({tag, ".rd_req"},  32'(ifc.rd_data_req),    32'd0);
        chk({tag, ".nack"},    32'(ifc.nack_det),       32'd0);
        chk({tag, ".busy"},    32'(ifc.busy_flag),      32'd0);
    endtask

    typedef struct {
        logic [7:0]  ab;
        int          n;
        logic [23:0] d;
        logic        e_ack;
        int          e_wr;
        logic [23:0] e_bytes;
        int          e_req;
        int          e_nack;
        logic        e_busy;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic a, busy_mid;
        logic [7:0] rb, ab;
        int w0, r0, k0, n;
        logic [23:0] d;
        logic match;

        // Byte 0 of each data word is sent first.
        tbl[0] = '{8'hA0, 2, 24'h003CA5, 1'b1, 2, 24'h003CA5, 0, 0, 1'b1};
        tbl[1] = '{8'hA2, 2, 24'h001234, 1'b0, 0, 24'h000000, 0, 0, 1'b0};
        tbl[2] = '{8'hA1, 2, 24'h00C33C, 1'b1, 0, 24'h00C33C, 2, 1, 1'b1};
        tbl[3] = '{8'hA0, 1, 24'h0000FF, 1'b1, 1, 24'h0000FF, 0, 0, 1'b1};
        tbl[4] = '{8'hA0, 3, 24'h800001, 1'b1, 3, 24'h800001, 0, 0, 1'b1};
        tbl[5] = '{8'hA1, 1, 24'h000000, 1'b1, 0, 24'h000000, 1, 1, 1'b1};
        tbl[6] = '{8'h20, 1, 24'h000055, 1'b0, 0, 24'h000000, 0, 0, 1'b0};

        ifc.rd_data_in = 8'h00;
        wait_clks(5);
        chk_reset_outputs("reset");
        reset = 1'b0;
        wait_clks(5);

        for (int i = 0; i < 7; i++)
            run_and_check($sformatf("tbl%0d", i), tbl[i].ab, tbl[i].n, tbl[i].d, tbl[i].e_ack,
                          tbl[i].e_wr, tbl[i].e_bytes, tbl[i].e_req, tbl[i].e_nack, tbl[i].e_busy);

        // Write one byte, repeated START into a one-byte read.
        w0 = wr_q.size(); r0 = n_req; k0 = n_nack;
        bus_start();
        put_byte(8'hA0, a);       chk("rs.addr_w_ack", 32'(a), 32'd0);
        put_byte(8'h10, a);       chk("rs.data_ack", 32'(a), 32'd0);
        ifc.rd_data_in = 8'h5A;
        bus_start();
        chk("rs.busy_at_restart", 32'(ifc.busy_flag), 32'd1);
        put_byte(8'hA1, a);       chk("rs.addr_r_ack", 32'(a), 32'd0);
        get_byte(rb);             chk("rs.rd_byte", 32'(rb), 32'h5A);
        put_bit(1'b1);
        chk("rs.busy_before_stop", 32'(ifc.busy_flag), 32'd1);
        bus_stop();
        wait_clks(4);
        chk("rs.wr_count", 32'(wr_q.size() - w0), 32'd1);
        if (wr_q.size() > w0) chk("rs.wr_byte", 32'(wr_q[w0]), 32'h10);
        chk("rs.rd_req", 32'(n_req - r0), 32'd1);
        chk("rs.nack", 32'(n_nack - k0), 32'd1);
        chk("rs.busy_after", 32'(ifc.busy_flag), 32'd0);

        // STOP four bits into a write data byte.
        w0 = wr_q.size();
        bus_start();
        put_byte(8'hA0, a);       chk("ps.addr_ack", 32'(a), 32'd0);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        bus_stop();
        wait_clks(4);
        chk("ps.wr_count", 32'(wr_q.size() - w0), 32'd0);
        chk("ps.busy", 32'(ifc.busy_flag), 32'd0);
        chk("ps.sda_e", 32'(ifc.i2c_sda_e), 32'd0);

        // Reset while the address ACK is being driven.
        bus_start();
        for (int i = 7; i >= 0; i--) put_bit(ab_const(i));
        chk("rst.ack_driven", 32'(ifc.i2c_sda_e), 32'd1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);
        bus_stop();
        run_and_check("rst.after", 8'hA0, 1, 24'h000077, 1'b1, 1, 24'h000077, 0, 0, 1'b1);

        // Randomized transactions against the transaction-level rules.
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1) ab = {DEV, 1'($urandom_range(0, 1))};
            else ab = 8'($urandom);
            n = $urandom_range(1, 3);
            d = 24'($urandom);
            match = (ab[7:1] == DEV);
            run_and_check($sformatf("rnd%0d", t), ab, n, d, match,
                          (match && !ab[0]) ? n : 0, d,
                          (match && ab[0]) ? n : 0,
                          (match && ab[0]) ? 1 : 0, match);
        end

        chk("pulse_rules", 32'(viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    function automatic logic ab_const(input int i);
        logic [7:0] v;
        v = 8'hA0;
        return v[i];
    endfunction

endmodule
